// File: rtl/sdp_ram_init.sv
`timescale 1ns/1ps
// sdp_ram_init: simple dual-port RAM with byte enables, write-first collisions and post-reset clear (SDP_RAM_OUT_REG_EN adds a read output stage)
module sdp_ram_init #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BE_W = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy,
  output logic              wr_err
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_err_q, wr_err_d, rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d, rd_word;
  logic wr_fire, rd_fire, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;

  // Clear counter walks the whole array once, then hands over to RUN
  always_comb begin
    state_d = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == INIT) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) state_d = RUN;
    end
  end

  // Write port mux: the clear sequence owns the array during INIT and user writes are dropped
  always_comb begin
    wr_fire = (state_q == RUN) && wr_en;
    rd_fire = (state_q == RUN) && rd_en;
    mem_we = (state_q == INIT) || wr_fire;
    mem_addr = (state_q == INIT) ? clr_addr_q : wr_addr;
    mem_wdata = (state_q == INIT) ? '0 : wr_data;
    mem_be = (state_q == INIT) ? '1 : wr_be;
    wr_err_d = (state_q == INIT) && wr_en;
  end

  // Write-first read: lanes written this cycle at the read address bypass the array
  always_comb begin
    rd_word = mem[rd_addr];
    for (int i = 0; i < BE_W; i++)
      if (wr_fire && wr_addr == rd_addr && wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
  end

  // Byte-lane array writes; contents are defined only by the clear sequence
  always_ff @(posedge clk)
    for (int i = 0; i < BE_W; i++)
      if (mem_we && mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];

`ifdef SDP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] pipe_q, pipe_d;
  logic pipe_v_q, pipe_v_d;

  // Two-stage read path: merge is captured at issue, second stage only re-times it
  always_comb begin
    pipe_v_d = rd_fire;
    pipe_d = rd_fire ? rd_word : pipe_q;
    rd_valid_d = pipe_v_q;
    rd_data_d = pipe_v_q ? pipe_q : rd_data_q;
  end

  // First read stage register; reset drops any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
      pipe_v_q <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      pipe_v_q <= pipe_v_d;
    end
  end
`else
  // Single-stage read path: result holds when no read is issued
  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d = rd_fire ? rd_word : rd_data_q;
  end
`endif

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      clr_addr_q <= '0;
      wr_err_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
      wr_err_q <= wr_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign init_busy = (state_q == INIT);
  assign wr_err = wr_err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_sdp_ram_init.sv
`timescale 1ns/1ps
// tb_sdp_ram_init: scoreboard bench for sdp_ram_init (DATA_W=16, ADDR_W=4)
module tb_sdp_ram_init;
`ifdef SDP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst_n = 0, wr_en = 0, rd_en = 0, rd_valid, init_busy, wr_err;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [15:0] wr_data = 0, rd_data;
  logic [1:0] wr_be = 0;
  typedef struct { logic [15:0] data; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int cyc = 0, n_chk = 0, n_fail = 0, n;

  sdp_ram_init #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .init_busy(init_busy), .wr_err(wr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic op(input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic [1:0] be,
                    input logic re, input logic [3:0] ra, input logic [15:0] want);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
    if (re) begin
      e.data = want;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic wait_init(input string name);
    int k = 0;
    while (init_busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, k, 16);
  endtask

  always @(negedge clk)
    if (rst_n && rd_valid) begin
      if (sb.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rd_data", rd_data, mon_e.data);
        chk("rd_latency", cyc - mon_e.cyc, LAT);
      end
    end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_wr_err", wr_err, 0);
    chk("reset_init_busy", init_busy, 1);
    rst_n = 1; wr_en = 1; wr_addr = 7; wr_data = 16'hFFFF; wr_be = 2'b11; rd_en = 1; rd_addr = 2;
    n = 0;
    while (init_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
      wr_en = 0;
      if (n == 1) chk("wr_err_pulse", wr_err, 1);
      if (n == 2) chk("wr_err_clear", wr_err, 0);
    end
    rd_en = 0;
    chk("init_busy_cycles", n, 16);
    for (int a = 0; a < 16; a++) op(0, 0, 0, 0, 1, 4'(a), 16'h0000);
    op(1, 3, 16'hBEEF, 2'b11, 0, 0, 0);
    chk("wr_err_run_write", wr_err, 0);
    op(0, 0, 0, 0, 1, 3, 16'hBEEF);
    op(1, 3, 16'h1234, 2'b01, 0, 0, 0);
    op(0, 0, 0, 0, 1, 3, 16'hBE34);
    op(1, 5, 16'h1111, 2'b11, 0, 0, 0);
    op(1, 5, 16'hAA55, 2'b10, 1, 5, 16'hAA11);
    op(0, 0, 0, 0, 1, 5, 16'hAA11);
    op(1, 6, 16'h5A5A, 2'b11, 1, 3, 16'hBE34);
    op(0, 0, 0, 0, 1, 6, 16'h5A5A);
    op(1, 3, 16'hFFFF, 2'b00, 0, 0, 0);
    chk("wr_err_be_zero", wr_err, 0);
    op(0, 0, 0, 0, 1, 3, 16'hBE34);
    op(1, 9, 16'hCAFE, 2'b11, 0, 0, 0);
    op(0, 0, 0, 0, 1, 9, 16'hCAFE);
    op(0, 0, 0, 0, 1, 4, 16'h0000);
    op(0, 0, 0, 0, 1, 9, 16'hCAFE);
    rst_n = 0;
    sb.delete();
    #1;
    chk("midreset_rd_data", rd_data, 0);
    chk("midreset_rd_valid", rd_valid, 0);
    chk("midreset_init_busy", init_busy, 1);
    @(posedge clk); #1;
    rst_n = 1;
    wait_init("reinit_busy_cycles");
    op(0, 0, 0, 0, 1, 9, 16'h0000);
    op(0, 0, 0, 0, 1, 5, 16'h0000);
    repeat (LAT + 2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
